lut4_cfg_ctrl: RTL and testbench

LUT4_CFG_CTRL -- requirements
Module: lut4_cfg_ctrl

---
 rtl/lut4_cfg_ctrl.sv | 153 +++++++++++++++
 tb/tb_lut4_cfg_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut4_cfg_ctrl.sv
// Byte-serial configuration controller for a bank of LUT4 cells: write, read back, clear.
// Latency: WRITE strobes cfg_we one cycle after its high byte; READ offers its low byte two cycles after the header.
// Backpressure: in_ready is high only in IDLE/WR_LO/WR_HI; readback bytes are held until out_ready.
module lut4_cfg_ctrl #(
  parameter int NUM_LUTS = 8,
  localparam int AW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          cfg_we,
  output logic [AW-1:0] cfg_addr,
  output logic [15:0]   cfg_data,
  input  logic [15:0]   cfg_rdata,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_LO  = 3'd1,
    S_WR_HI  = 3'd2,
    S_COMMIT = 3'd3,
    S_RD_CAP = 3'd4,
    S_RD_LO  = 3'd5,
    S_RD_HI  = 3'd6,
    S_CLEAR  = 3'd7
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic            idx_bad_q;
  logic [7:0]      wlo_q, whi_q;
  logic [15:0]     cap_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            err_q;

  logic            accept;
  logic [1:0]      hdr_op;
  logic [5:0]      hdr_idx;
  logic            hdr_bad;
  logic            clr_last;

  assign accept   = in_valid & in_ready;
  assign hdr_op   = in_data[7:6];
  assign hdr_idx  = in_data[5:0];
  // Index is 6 bits wide, so anything at or above the bank size is out of range.
  assign hdr_bad  = ({1'b0, hdr_idx} >= 7'(NUM_LUTS));
  assign clr_last = (clr_cnt_q == AW'(NUM_LUTS - 1));

  // State register; reset drops any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode from the header byte and the handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (hdr_op)
            OP_WRITE: state_d = S_WR_LO;
            OP_READ:  state_d = hdr_bad ? S_IDLE : S_RD_CAP;
            OP_CLEAR: state_d = S_CLEAR;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_WR_LO:  if (accept) state_d = S_WR_HI;
      S_WR_HI:  if (accept) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      S_RD_CAP: state_d = S_RD_LO;
      S_RD_LO:  if (out_ready) state_d = S_RD_HI;
      S_RD_HI:  if (out_ready) state_d = S_IDLE;
      S_CLEAR:  if (clr_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: header fields, write bytes, readback capture, clear counter, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      idx_bad_q <= 1'b0;
      wlo_q     <= '0;
      whi_q     <= '0;
      cap_q     <= '0;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && accept) begin
        idx_q     <= hdr_idx[AW-1:0];
        idx_bad_q <= hdr_bad;
        clr_cnt_q <= '0;
        if ((hdr_op == OP_WRITE || hdr_op == OP_READ) && hdr_bad) err_q <= 1'b1;
      end
      if (state_q == S_WR_LO && accept) wlo_q <= in_data;
      if (state_q == S_WR_HI && accept) whi_q <= in_data;
      if (state_q == S_RD_CAP) cap_q <= cfg_rdata;
      if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // Outputs are a pure function of state so reset forces them all low at once.
  always_comb begin
    in_ready  = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE, S_WR_LO, S_WR_HI: in_ready = ~rst;
      S_COMMIT: begin
        // Out-of-range writes still walk the framing but never touch the bank.
        if (!idx_bad_q) begin
          cfg_we   = 1'b1;
          cfg_addr = idx_q;
          cfg_data = {whi_q, wlo_q};
        end
      end
      S_RD_CAP: cfg_addr = idx_q;
      S_RD_LO: begin
        out_valid = 1'b1;
        out_data  = cap_q[7:0];
      end
      S_RD_HI: begin
        out_valid = 1'b1;
        out_data  = cap_q[15:8];
      end
      S_CLEAR: begin
        cfg_we   = 1'b1;
        cfg_addr = clr_cnt_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_lut4_cfg_ctrl.sv
// Testbench for lut4_cfg_ctrl: directed scenarios plus randomized command stream.
// A behavioural LUT bank model tracks expected contents and the sticky error flag.
// A second instance with six LUTs covers the out-of-range index cases.
module tb_lut4_cfg_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_valid6;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready, cfg_we, out_valid, busy, err;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data, cfg_rdata;
  logic [7:0]  out_data;

  logic        in_ready6, cfg_we6, out_valid6, busy6, err6;
  logic [2:0]  cfg_addr6;
  logic [15:0] cfg_data6;
  logic [15:0] cfg_rdata6;
  logic [7:0]  out_data6;
  logic        out_ready6;

  int total = 0;
  int bad   = 0;

  lut4_cfg_ctrl #(.NUM_LUTS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_rdata(cfg_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  lut4_cfg_ctrl #(.NUM_LUTS(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_data(in_data), .in_ready(in_ready6),
    .cfg_we(cfg_we6), .cfg_addr(cfg_addr6), .cfg_data(cfg_data6), .cfg_rdata(cfg_rdata6),
    .out_valid(out_valid6), .out_data(out_data6), .out_ready(out_ready6),
    .busy(busy6), .err(err6)
  );

  assign cfg_rdata6 = 16'h0000;
  assign out_ready6 = 1'b1;

  // LUT bank attached to the main instance.
  logic [15:0] bank [8];
  always @(posedge clk) if (cfg_we) bank[cfg_addr] <= cfg_data;
  assign cfg_rdata = bank[cfg_addr];

  // Strobe monitors, sampled mid-cycle.
  int          we_cnt = 0, we6_cnt = 0, ov6_cnt = 0;
  logic [2:0]  last_addr;
  logic [15:0] last_data;
  always @(negedge clk) begin
    if (cfg_we) begin
      we_cnt++;
      last_addr = cfg_addr;
      last_data = cfg_data;
    end
    if (cfg_we6)    we6_cnt++;
    if (out_valid6) ov6_cnt++;
  end

  // Offer one byte to the selected instance; returns 1 time unit after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data = b;
    if (sel) in_valid6 = 1'b1; else in_valid = 1'b1;
    n = 0;
    while (!(sel ? in_ready6 : in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%h in_ready never rose", b);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid  = 1'b0;
    in_valid6 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL idle_timeout busy still %b", busy);
    end
  endtask

  // Take one readback byte after a random stall, checking it holds meanwhile.
  task automatic recv(output logic [7:0] d);
    int n;
    logic [7:0] first;
    n = 0;
    d = 8'h00;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL recv_timeout out_valid never rose");
    end else begin
      first = out_data;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== first) begin
        bad++;
        $display("FAIL recv_hold got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, first);
      end
      out_ready = 1'b1;
      d = out_data;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 8'h45;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({in_ready, cfg_we, cfg_addr, cfg_data, out_valid, out_data, busy, err} !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got in_ready=%b we=%b addr=%h data=%h ov=%b od=%h busy=%b err=%b want all 0",
                 i, in_ready, cfg_we, cfg_addr, cfg_data, out_valid, out_data, busy, err);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b busy=%b err=%b want 1 0 0", in_ready, busy, err);
    end
  endtask

  task automatic test_write();
    int w0;
    w0 = we_cnt;
    send(0, 8'h45);
    send(0, 8'h96);
    send(0, 8'h69);
    @(negedge clk);
    total++;
    if (cfg_we !== 1'b1 || cfg_addr !== 3'd5 || cfg_data !== 16'h6996 || busy !== 1'b1) begin
      bad++;
      $display("FAIL write_commit got we=%b addr=%0d data=%h busy=%b want 1 5 6996 1", cfg_we, cfg_addr, cfg_data, busy);
    end
    @(negedge clk);
    total++;
    if (cfg_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_done got we=%b busy=%b in_ready=%b want 0 0 1", cfg_we, busy, in_ready);
    end
    #1;
    total++;
    if (we_cnt - w0 !== 1) begin
      bad++;
      $display("FAIL write_pulses got %0d want 1", we_cnt - w0);
    end
  endtask

  task automatic test_read();
    send(0, 8'h43);
    send(0, 8'hEF);
    send(0, 8'hBE);
    wait_idle();
    out_ready = 1'b0;
    send(0, 8'h83);
    @(negedge clk);
    total++;
    if (cfg_addr !== 3'd3 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL read_cap got addr=%0d ov=%b in_ready=%b want 3 0 0", cfg_addr, out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hEF) begin
        bad++;
        $display("FAIL read_lo_hold cycle=%0d got ov=%b data=%h want 1 ef", i, out_valid, out_data);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hEF) begin
      bad++;
      $display("FAIL read_lo_take got ov=%b data=%h want 1 ef", out_valid, out_data);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hBE) begin
      bad++;
      $display("FAIL read_hi got ov=%b data=%h want 1 be", out_valid, out_data);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL read_done got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    logic [2:0] kk;
    send(0, 8'hC0);
    in_valid = 1'b1;
    in_data  = 8'h45;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      kk = 3'(k);
      total++;
      if ({cfg_we, cfg_addr, cfg_data, in_ready, busy} !== {1'b1, kk, 16'h0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL clear_step k=%0d got we=%b addr=%0d data=%h in_ready=%b busy=%b want 1 %0d 0000 0 1",
                 k, cfg_we, cfg_addr, cfg_data, in_ready, busy, k);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (cfg_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_done got we=%b busy=%b want 0 0", cfg_we, busy);
    end
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bank[i] !== 16'h0) begin
        bad++;
        $display("FAIL clear_bank idx=%0d got %h want 0000", i, bank[i]);
      end
    end
  endtask

  task automatic test_bad_index();
    int w6, o6;
    w6 = we6_cnt;
    o6 = ov6_cnt;
    send(1, 8'h47);
    total++;
    if (err6 !== 1'b1) begin
      bad++;
      $display("FAIL bad_err_set got err=%b want 1", err6);
    end
    send(1, 8'h12);
    send(1, 8'h34);
    send(1, 8'h86);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (we6_cnt != w6 || ov6_cnt != o6) begin
      bad++;
      $display("FAIL bad_no_strobe got we=%0d ov=%0d want 0 0", we6_cnt - w6, ov6_cnt - o6);
    end
    total++;
    if (err6 !== 1'b1 || busy6 !== 1'b0 || in_ready6 !== 1'b1) begin
      bad++;
      $display("FAIL bad_end got err=%b busy=%b in_ready=%b want 1 0 1", err6, busy6, in_ready6);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL bad_isolation main err got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    w0 = we_cnt;
    send(0, 8'h43);
    send(0, 8'h11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || cfg_we !== 1'b0) begin
      bad++;
      $display("FAIL midrst_during got in_ready=%b busy=%b we=%b want 0 0 0", in_ready, busy, cfg_we);
    end
    @(negedge clk);
    rst = 1'b0;
    send(0, 8'h43);
    send(0, 8'hAA);
    send(0, 8'h55);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (we_cnt - w0 !== 1 || last_addr !== 3'd3 || last_data !== 16'h55AA) begin
      bad++;
      $display("FAIL midrst_write got pulses=%0d addr=%0d data=%h want 1 3 55aa", we_cnt - w0, last_addr, last_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_bank [8];
    logic        exp_err;
    logic [1:0]  op;
    logic [5:0]  idx;
    logic [7:0]  lo, hi, b0, b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    send(0, 8'hC0);
    for (int i = 0; i < 8; i++) exp_bank[i] = 16'h0;
    wait_idle();
    for (int t = 0; t < 60; t++) begin
      op  = 2'($urandom_range(0, 3));
      idx = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(8, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(0, {op, idx});
      case (op)
        2'b01: begin
          lo = 8'($urandom);
          hi = 8'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(0, lo);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(0, hi);
          if (idx < 8) exp_bank[idx[2:0]] = {hi, lo};
          else         exp_err = 1'b1;
        end
        2'b10: begin
          if (idx < 8) begin
            recv(b0);
            recv(b1);
            total++;
            if ({b1, b0} !== exp_bank[idx[2:0]]) begin
              bad++;
              $display("FAIL rand_read idx=%0d got %h want %h", idx, {b1, b0}, exp_bank[idx[2:0]]);
            end
          end else begin
            exp_err = 1'b1;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
              bad++;
              $display("FAIL rand_badread idx=%0d got ov=%b busy=%b want 0 0", idx, out_valid, busy);
            end
          end
        end
        2'b11: for (int i = 0; i < 8; i++) exp_bank[i] = 16'h0;
        default: ;
      endcase
      wait_idle();
      total++;
      if (err !== exp_err) begin
        bad++;
        $display("FAIL rand_err step=%0d got %b want %b", t, err, exp_err);
      end
    end
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bank[i] !== exp_bank[i]) begin
        bad++;
        $display("FAIL rand_bank idx=%0d got %h want %h", i, bank[i], exp_bank[i]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valid6 = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_clear();
    test_bad_index();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
